// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks writers in EX/MEM/WB and raises the ID interlock
// Ports: ID operands/dest/flags in; Stall_IF/ID, Bubble_EX, Load_Use_Hazard, Stall_Count out
// Optional: define HAZARD_STALL_COUNT_EN to build the saturating stall counter
module hazard_scoreboard #(
  parameter int RF_WRITE_THROUGH = 1,
  parameter int REG_ADDR_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic                  Rs1_Valid_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  Rs2_Valid_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic                  Write_Enable_ID,
  input  logic                  I_Type_Load_ID,
  input  logic                  Valid_ID,
  input  logic                  Flush_ID,
  input  logic                  Hold_Pipe,
  output logic                  Stall_IF,
  output logic                  Stall_ID,
  output logic                  Bubble_EX,
  output logic                  Load_Use_Hazard,
  output logic [15:0]           Stall_Count
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  // The load flag only matters while the writer sits in EX; past that
  // point the forwarding network covers it, so MEM/WB drop the flag.
  typedef struct packed {
    logic v;
    reg_t rd;
    logic ld;
  } ex_slot_t;

  typedef struct packed {
    logic v;
    reg_t rd;
  } slot_t;

  ex_slot_t sl_ex;
  ex_slot_t ex_nxt;
  slot_t    sl_mem;
  slot_t    sl_wb;

  logic hit1_ex;
  logic hit2_ex;
  logic hit1_wb;
  logic hit2_wb;
  logic wt_off;
  logic luh;
  logic wbh;
  logic haz;
  logic capture;

  function automatic logic src_hit(
    input logic use_rs,
    input reg_t rs,
    input logic sv,
    input reg_t srd
  );
    return use_rs && (rs != '0) && sv && (srd == rs);
  endfunction

  assign hit1_ex = src_hit(Rs1_Valid_ID, rs1_ID,
                           sl_ex.v, sl_ex.rd);
  assign hit2_ex = src_hit(Rs2_Valid_ID, rs2_ID,
                           sl_ex.v, sl_ex.rd);
  assign hit1_wb = src_hit(Rs1_Valid_ID, rs1_ID,
                           sl_wb.v, sl_wb.rd);
  assign hit2_wb = src_hit(Rs2_Valid_ID, rs2_ID,
                           sl_wb.v, sl_wb.rd);

  // Without write-through the RF read in ID misses the WB write.
  assign wt_off = (RF_WRITE_THROUGH == 0);

  assign luh = Valid_ID & sl_ex.ld
             & (hit1_ex | hit2_ex);
  assign wbh = Valid_ID & wt_off
             & (hit1_wb | hit2_wb);

  // A flushed ID instruction is dropped, so it never stalls.
  assign haz = (luh | wbh) & ~Flush_ID;

  assign Stall_IF        = haz | Hold_Pipe;
  assign Stall_ID        = haz | Hold_Pipe;
  assign Bubble_EX       = haz & ~Hold_Pipe;
  assign Load_Use_Hazard = luh & ~Flush_ID;

  // x0 writers are never tracked; stalled or flushed
  // instructions enter EX as a bubble.
  assign capture = Valid_ID & Write_Enable_ID
                 & (rd_ID != '0)
                 & ~haz & ~Flush_ID;

  always_comb begin
    ex_nxt    = '0;
    ex_nxt.v  = capture;
    ex_nxt.rd = capture ? rd_ID : '0;
    ex_nxt.ld = capture & I_Type_Load_ID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ex  <= '0;
      sl_mem <= '0;
      sl_wb  <= '0;
    end else if (!Hold_Pipe) begin
      sl_wb.v   <= sl_mem.v;
      sl_wb.rd  <= sl_mem.rd;
      sl_mem.v  <= sl_ex.v;
      sl_mem.rd <= sl_ex.rd;
      sl_ex     <= ex_nxt;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (haz && !Hold_Pipe &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign Stall_Count = stall_cnt;
`else
  assign Stall_Count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard
// Two instances (write-through on/off) checked against an age-indexed writer history
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       Rs1_Valid_ID, Rs2_Valid_ID;
  logic       Write_Enable_ID, I_Type_Load_ID;
  logic       Valid_ID, Flush_ID, Hold_Pipe;

  logic        si1, sd1, bx1, lu1;
  logic        si0, sd0, bx0, lu0;
  logic [15:0] sc1, sc0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .RF_WRITE_THROUGH(1),
    .REG_ADDR_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .Rs1_Valid_ID(Rs1_Valid_ID),
    .rs2_ID(rs2_ID), .Rs2_Valid_ID(Rs2_Valid_ID),
    .rd_ID(rd_ID), .Write_Enable_ID(Write_Enable_ID),
    .I_Type_Load_ID(I_Type_Load_ID), .Valid_ID(Valid_ID),
    .Flush_ID(Flush_ID), .Hold_Pipe(Hold_Pipe),
    .Stall_IF(si1), .Stall_ID(sd1), .Bubble_EX(bx1),
    .Load_Use_Hazard(lu1), .Stall_Count(sc1)
  );

  hazard_scoreboard #(
    .RF_WRITE_THROUGH(0),
    .REG_ADDR_W(5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .Rs1_Valid_ID(Rs1_Valid_ID),
    .rs2_ID(rs2_ID), .Rs2_Valid_ID(Rs2_Valid_ID),
    .rd_ID(rd_ID), .Write_Enable_ID(Write_Enable_ID),
    .I_Type_Load_ID(I_Type_Load_ID), .Valid_ID(Valid_ID),
    .Flush_ID(Flush_ID), .Hold_Pipe(Hold_Pipe),
    .Stall_IF(si0), .Stall_ID(sd0), .Bubble_EX(bx0),
    .Load_Use_Hazard(lu0), .Stall_Count(sc0)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Model: per instance, the last three issued instructions by age
  // (0 = one edge ago = EX, 2 = three edges ago = WB).
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } w_t;

  w_t          h [2][3];
  logic        mhaz [2];
  logic        mlu  [2];
  logic        wbh;
  logic [15:0] mcnt [2];

  function automatic logic src(input logic [4:0] r,
                               input logic [4:0] a,
                               input logic va);
    return va && (r != 5'd0) && (a == r);
  endfunction

  function automatic logic reads(input logic [4:0] r,
                                 input logic [4:0] a1,
                                 input logic v1,
                                 input logic [4:0] a2,
                                 input logic v2);
    return src(r, a1, v1) || src(r, a2, v2);
  endfunction

  // index 1 = write-through, index 0 = no write-through
  always_comb begin
    wbh = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mlu[i] = Valid_ID && h[i][0].v && h[i][0].ld &&
               reads(h[i][0].rd, rs1_ID, Rs1_Valid_ID,
                     rs2_ID, Rs2_Valid_ID);
      wbh = (i == 0) && Valid_ID && h[i][2].v &&
            reads(h[i][2].rd, rs1_ID, Rs1_Valid_ID,
                  rs2_ID, Rs2_Valid_ID);
      mhaz[i] = (mlu[i] || wbh) && !Flush_ID;
      mlu[i]  = mlu[i] && !Flush_ID;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i] <= 16'd0;
        for (int k = 0; k < 3; k++) h[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mhaz[i] && !Hold_Pipe && mcnt[i] != 16'hFFFF)
          mcnt[i] <= mcnt[i] + 16'd1;
        if (!Hold_Pipe) begin
          h[i][2] <= h[i][1];
          h[i][1] <= h[i][0];
          h[i][0] <= '{v: Valid_ID && Write_Enable_ID &&
                          !mhaz[i] && !Flush_ID,
                       rd: rd_ID, ld: I_Type_Load_ID};
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [15:0] ec;
`ifdef HAZARD_STALL_COUNT_EN
      ec = mcnt[i];
`else
      ec = 16'd0;
`endif
      chk($sformatf("m%0d.stall_if", i),
          32'(i == 1 ? si1 : si0), 32'(mhaz[i] | Hold_Pipe));
      chk($sformatf("m%0d.stall_id", i),
          32'(i == 1 ? sd1 : sd0), 32'(mhaz[i] | Hold_Pipe));
      chk($sformatf("m%0d.bubble", i),
          32'(i == 1 ? bx1 : bx0), 32'(mhaz[i] & !Hold_Pipe));
      chk($sformatf("m%0d.luh", i),
          32'(i == 1 ? lu1 : lu0), 32'(mlu[i]));
      chk($sformatf("m%0d.cnt", i),
          32'(i == 1 ? sc1 : sc0), 32'(ec));
    end
  end

  task automatic lit(input string nm, input logic s,
                     input logic b, input logic l);
    chk({nm, ".stall_if"}, 32'(si1), 32'(s));
    chk({nm, ".stall_id"}, 32'(sd1), 32'(s));
    chk({nm, ".bubble"},   32'(bx1), 32'(b));
    chk({nm, ".luh"},      32'(lu1), 32'(l));
  endtask

  task automatic lit0(input string nm, input logic s,
                      input logic b, input logic l);
    chk({nm, ".wt0_stall"},  32'(si0), 32'(s));
    chk({nm, ".wt0_bubble"}, 32'(bx0), 32'(b));
    chk({nm, ".wt0_luh"},    32'(lu0), 32'(l));
  endtask

  task automatic go(input logic [4:0] r1, input logic v1,
                    input logic [4:0] r2, input logic v2,
                    input logic [4:0] rd, input logic we,
                    input logic ld, input logic val,
                    input logic fl, input logic hd);
    @(posedge clk);
    #1;
    rs1_ID = r1; Rs1_Valid_ID = v1;
    rs2_ID = r2; Rs2_Valid_ID = v2;
    rd_ID = rd; Write_Enable_ID = we;
    I_Type_Load_ID = ld; Valid_ID = val;
    Flush_ID = fl; Hold_Pipe = hd;
    @(negedge clk);
  endtask

  task automatic ins(input logic [4:0] rd, input logic we,
                     input logic ld,
                     input logic [4:0] r1, input logic v1,
                     input logic [4:0] r2, input logic v2);
    go(r1, v1, r2, v2, rd, we, ld, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    go(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
       1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] c0;
    rst_n = 1'b0;
    rs1_ID = '0; Rs1_Valid_ID = 1'b0;
    rs2_ID = '0; Rs2_Valid_ID = 1'b0;
    rd_ID = '0; Write_Enable_ID = 1'b0;
    I_Type_Load_ID = 1'b0; Valid_ID = 1'b0;
    Flush_ID = 1'b0; Hold_Pipe = 1'b0;
    @(negedge clk);
    lit("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", 32'(sc1), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // load-use: lw x5 ; add x6,x5,x7
    ins(5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
    lit("lw5", 0, 0, 0);
    ins(5'd6, 1, 0, 5'd5, 1, 5'd7, 1);
    lit("lu.stall", 1, 1, 1);
    ins(5'd6, 1, 0, 5'd5, 1, 5'd7, 1);
    lit("lu.issue", 0, 0, 0);

    // ALU dependency is forwarded
    ins(5'd5, 1, 0, 5'd2, 1, 5'd3, 1);
    lit("alu.p", 0, 0, 0);
    ins(5'd6, 1, 0, 5'd5, 1, 5'd1, 1);
    lit("alu.c", 0, 0, 0);

    // x0 writer is never tracked
    ins(5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd1, 1, 0, 5'd0, 1, 5'd0, 1);
    lit("x0", 0, 0, 0);

    // unused source field
    ins(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd2, 1, 0, 5'd0, 0, 5'd9, 0);
    lit("rs2inv", 0, 0, 0);

    // flush beats hazard; flushed load x11 not captured
    ins(5'd10, 1, 1, 5'd0, 0, 5'd0, 0);
    go(5'd10, 1, 5'd0, 0, 5'd11, 1, 1, 1, 1, 0);
    lit("flush", 0, 0, 0);
    ins(5'd12, 1, 0, 5'd11, 1, 5'd0, 0);
    lit("flush.after", 0, 0, 0);

    // hold freezes slots, hazard resumes once
    ins(5'd12, 1, 1, 5'd0, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      go(5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 1, 0, 1);
      lit($sformatf("hold%0d", k), 1, 0, 1);
    end
    ins(5'd13, 1, 0, 5'd12, 1, 5'd0, 0);
    lit("hold.resume", 1, 1, 1);
    ins(5'd13, 1, 0, 5'd12, 1, 5'd0, 0);
    lit("hold.issue", 0, 0, 0);

    // back-to-back loads
    ins(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd6, 1, 1, 5'd5, 1, 5'd0, 0);
    lit("b2b.stall", 1, 1, 1);
    ins(5'd6, 1, 1, 5'd5, 1, 5'd0, 0);
    lit("b2b.issue", 0, 0, 0);
    ins(5'd7, 1, 0, 5'd6, 1, 5'd0, 0);
    lit("b2b.use2", 1, 1, 1);
    ins(5'd7, 1, 0, 5'd6, 1, 5'd0, 0);
    lit("b2b.done", 0, 0, 0);

    // WB read without write-through
    nop(); nop(); nop();
    c0 = sc0;
    ins(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    nop(); nop();
    ins(5'd4, 1, 0, 5'd3, 1, 5'd3, 1);
    lit0("wb", 1, 1, 0);
    lit("wb.wt1", 0, 0, 0);
    ins(5'd4, 1, 0, 5'd3, 1, 5'd3, 1);
    lit0("wb.issue", 0, 0, 0);
`ifdef HAZARD_STALL_COUNT_EN
    chk("wb.cnt_delta", 32'(sc0 - c0), 32'd1);
`else
    chk("wb.cnt_off", 32'(sc0), 32'd0);
`endif

    // reset during a stall drops it at once
    ins(5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd8, 1, 0, 5'd7, 1, 5'd0, 0);
    lit("rst.pre", 1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    lit("rst.async", 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    lit("rst.after", 0, 0, 0);
    nop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
